// File: rtl/bbox_locate_isp_if.sv
// Video-in / bounding-box-out bundle for bbox_locate_isp.
// The master drives the mask stream and timing; the slave (the locator) drives the window bounds.
interface bbox_locate_isp_if #(
  parameter int CNT_W  = 12,
  parameter int PCNT_W = 20
) ();
  logic              i_bin;
  logic              i_hsync;
  logic              i_vsync;
  logic              i_de;
  logic [CNT_W-1:0]  hcount_l;
  logic [CNT_W-1:0]  hcount_r;
  logic [CNT_W-1:0]  vcount_l;
  logic [CNT_W-1:0]  vcount_r;
  logic              o_valid;
  logic              o_frame_done;
  logic [PCNT_W-1:0] o_pix_cnt;

  modport master (
    output i_bin, i_hsync, i_vsync, i_de,
    input  hcount_l, hcount_r, vcount_l, vcount_r, o_valid, o_frame_done, o_pix_cnt
  );

  modport slave (
    input  i_bin, i_hsync, i_vsync, i_de,
    output hcount_l, hcount_r, vcount_l, vcount_r, o_valid, o_frame_done, o_pix_cnt
  );
endinterface

// File: rtl/bbox_locate_isp.sv
// Streaming foreground bounding-box locator; publishes exclusive window bounds at each vsync edge.
// Optional `BBOX_MARGIN_EN widens the box by MARGIN (clamped) and adds one publish pipeline stage.
module bbox_locate_isp #(
  parameter int CNT_W      = 12,
  parameter int MIN_PIXELS = 64,
  parameter int PCNT_W     = 20,
  parameter int SYNC_POL   = 1,
  parameter int MARGIN     = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480
) (
  input  logic             pixelclk,
  input  logic             reset_n,
  bbox_locate_isp_if.slave bus
);

  localparam logic              POL  = (SYNC_POL != 0);
  localparam logic [CNT_W-1:0]  CMAX = '1;
  localparam logic [CNT_W-1:0]  X1   = CNT_W'(1);
  localparam logic [CNT_W:0]    W1   = (CNT_W+1)'(1);
  localparam logic [PCNT_W-1:0] PMAX = '1;
  localparam logic [PCNT_W-1:0] P1   = PCNT_W'(1);
  localparam logic [PCNT_W-1:0] PMIN = PCNT_W'(MIN_PIXELS);
`ifdef BBOX_MARGIN_EN
  localparam logic MARGIN_ON = 1'b1;
`else
  localparam logic MARGIN_ON = 1'b0;
`endif
  localparam logic [CNT_W:0] M_EFF = MARGIN_ON ? (CNT_W+1)'(MARGIN) : (CNT_W+1)'(0);
  localparam logic [CNT_W:0] H_LIM = MARGIN_ON ? (CNT_W+1)'(H_ACTIVE) : {1'b0, CMAX};
  localparam logic [CNT_W:0] V_LIM = MARGIN_ON ? (CNT_W+1)'(V_ACTIVE) : {1'b0, CMAX};

  // Without the margin feature M_EFF is 0 and the limits are all-ones, giving the exact bounds.
  function automatic logic [CNT_W-1:0] lo_bound(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] t;
    t = (v == '0) ? '0 : ({1'b0, v} - W1);
    t = (t < M_EFF) ? '0 : (t - M_EFF);
    return t[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] hi_bound(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W:0]   lim);
    logic [CNT_W:0] t;
    t = (v == CMAX) ? {1'b0, CMAX} : ({1'b0, v} + W1);
    t = t + M_EFF;
    if (t > lim) t = lim;
    return t[CNT_W-1:0];
  endfunction

  logic r_bin1, r_de1, r_hs1, r_vs1, r_vs_act_d, r_de_d, r_armed;
  logic [CNT_W-1:0]  r_x, r_y, r_xmin, r_xmax, r_ymin, r_ymax;
  logic [PCNT_W-1:0] r_pcnt;
  logic [CNT_W-1:0]  r_hl, r_hr, r_vl, r_vr;
  logic              r_valid, r_done;
  logic [PCNT_W-1:0] r_pix_cnt;

  logic w_vs_act, w_vs_edge, w_hs_act, w_de_fall, w_hit, w_pub, w_ok;
  logic [CNT_W-1:0] w_hl, w_hr, w_vl, w_vr;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_bin1     <= 1'b0;
      r_de1      <= 1'b0;
      r_hs1      <= ~POL;
      r_vs1      <= ~POL;
      r_vs_act_d <= 1'b0;
      r_de_d     <= 1'b0;
    end else begin
      r_bin1     <= bus.i_bin;
      r_de1      <= bus.i_de;
      r_hs1      <= bus.i_hsync;
      r_vs1      <= bus.i_vsync;
      r_vs_act_d <= w_vs_act;
      r_de_d     <= r_de1;
    end
  end

  assign w_vs_act  = (r_vs1 == POL);
  assign w_hs_act  = (r_hs1 == POL);
  assign w_vs_edge = w_vs_act & ~r_vs_act_d;
  assign w_de_fall = r_de_d & ~r_de1;
  assign w_hit     = r_de1 & r_bin1 & ~w_vs_edge;

  // hsync only ever lands in blanking where x is already cleared; it just guards odd timing.
  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (r_de1) begin
        if (r_x != CMAX) r_x <= r_x + X1;
      end else if (w_de_fall || w_hs_act) begin
        r_x <= '0;
      end
      if (w_vs_edge)                      r_y <= '0;
      else if (w_de_fall && r_y != CMAX) r_y <= r_y + X1;
    end
  end

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_xmin  <= '1;
      r_xmax  <= '0;
      r_ymin  <= '1;
      r_ymax  <= '0;
      r_pcnt  <= '0;
      r_armed <= 1'b0;
    end else if (w_vs_edge) begin
      r_xmin  <= '1;
      r_xmax  <= '0;
      r_ymin  <= '1;
      r_ymax  <= '0;
      r_pcnt  <= '0;
      r_armed <= 1'b1;
    end else if (w_hit) begin
      if (r_x < r_xmin) r_xmin <= r_x;
      if (r_x > r_xmax) r_xmax <= r_x;
      if (r_y < r_ymin) r_ymin <= r_y;
      if (r_y > r_ymax) r_ymax <= r_y;
      if (r_pcnt != PMAX) r_pcnt <= r_pcnt + P1;
    end
  end

  assign w_pub = w_vs_edge & r_armed;
  assign w_ok  = (r_pcnt >= PMIN);
  assign w_hl  = lo_bound(r_xmin);
  assign w_hr  = hi_bound(r_xmax, H_LIM);
  assign w_vl  = lo_bound(r_ymin);
  assign w_vr  = hi_bound(r_ymax, V_LIM);

  logic              w_s_pub, w_s_ok;
  logic [PCNT_W-1:0] w_s_cnt;
  logic [CNT_W-1:0]  w_s_hl, w_s_hr, w_s_vl, w_s_vr;

`ifdef BBOX_MARGIN_EN
  logic              r_s_pub, r_s_ok;
  logic [PCNT_W-1:0] r_s_cnt;
  logic [CNT_W-1:0]  r_s_hl, r_s_hr, r_s_vl, r_s_vr;

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_s_pub <= 1'b0;
      r_s_ok  <= 1'b0;
      r_s_cnt <= '0;
      r_s_hl  <= '0;
      r_s_hr  <= '0;
      r_s_vl  <= '0;
      r_s_vr  <= '0;
    end else begin
      r_s_pub <= w_pub;
      if (w_pub) begin
        r_s_ok  <= w_ok;
        r_s_cnt <= r_pcnt;
        r_s_hl  <= w_hl;
        r_s_hr  <= w_hr;
        r_s_vl  <= w_vl;
        r_s_vr  <= w_vr;
      end
    end
  end

  assign w_s_pub = r_s_pub;
  assign w_s_ok  = r_s_ok;
  assign w_s_cnt = r_s_cnt;
  assign w_s_hl  = r_s_hl;
  assign w_s_hr  = r_s_hr;
  assign w_s_vl  = r_s_vl;
  assign w_s_vr  = r_s_vr;
`else
  assign w_s_pub = w_pub;
  assign w_s_ok  = w_ok;
  assign w_s_cnt = r_pcnt;
  assign w_s_hl  = w_hl;
  assign w_s_hr  = w_hr;
  assign w_s_vl  = w_vl;
  assign w_s_vr  = w_vr;
`endif

  always_ff @(posedge pixelclk or negedge reset_n) begin
    if (!reset_n) begin
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_pix_cnt <= '0;
      r_hl      <= '0;
      r_hr      <= '0;
      r_vl      <= '0;
      r_vr      <= '0;
    end else begin
      r_done <= w_s_pub;
      if (w_s_pub) begin
        r_valid   <= w_s_ok;
        r_pix_cnt <= w_s_cnt;
        if (w_s_ok) begin
          r_hl <= w_s_hl;
          r_hr <= w_s_hr;
          r_vl <= w_s_vl;
          r_vr <= w_s_vr;
        end
      end
    end
  end

  assign bus.hcount_l     = r_hl;
  assign bus.hcount_r     = r_hr;
  assign bus.vcount_l     = r_vl;
  assign bus.vcount_r     = r_vr;
  assign bus.o_valid      = r_valid;
  assign bus.o_frame_done = r_done;
  assign bus.o_pix_cnt    = r_pix_cnt;

endmodule

// File: tb/tb_bbox_locate_isp.sv
// Scoreboard bench for bbox_locate_isp: expected boxes are queued at each vsync and
// compared when o_frame_done fires. Honours `BBOX_MARGIN_EN for margin and latency.
module tb_bbox_locate_isp;

`ifdef BBOX_MARGIN_EN
  localparam int LAT = 3;
  localparam int MG  = 8;
`else
  localparam int LAT = 2;
  localparam int MG  = 0;
`endif
  localparam int MINP = 64;

  localparam int M_PART   = 0;
  localparam int M_BLOCK  = 1;
  localparam int M_SPARSE = 2;
  localparam int M_CORNER = 3;
  localparam int M_EMPTY  = 4;
  localparam int M_TALL   = 5;

  typedef struct {
    logic [31:0] v;
    logic [31:0] cnt;
    logic [31:0] hl, hr, vl, vr;
    logic [31:0] cyc;
  } exp_t;

  logic pixelclk = 1'b0;
  logic reset_n  = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc      = 0;
  int unsigned pulses   = 0;
  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] p_hl = 0, p_hr = 0, p_vl = 0, p_vr = 0;

  bbox_locate_isp_if #(.CNT_W(12), .PCNT_W(20)) bus ();

  bbox_locate_isp #(
    .CNT_W(12), .MIN_PIXELS(MINP), .PCNT_W(20), .SYNC_POL(1),
    .MARGIN(8), .H_ACTIVE(640), .V_ACTIVE(480)
  ) dut (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 pixelclk = ~pixelclk;
  always @(posedge pixelclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge pixelclk) begin
    if (bus.o_frame_done === 1'b1) begin
      pulses++;
      check("pulse_expected", {31'd0, q.size() != 0}, 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("o_valid",   {31'd0, bus.o_valid}, mon_e.v);
        check("o_pix_cnt", {12'd0, bus.o_pix_cnt}, mon_e.cnt);
        check("hcount_l",  {20'd0, bus.hcount_l}, mon_e.hl);
        check("hcount_r",  {20'd0, bus.hcount_r}, mon_e.hr);
        check("vcount_l",  {20'd0, bus.vcount_l}, mon_e.vl);
        check("vcount_r",  {20'd0, bus.vcount_r}, mon_e.vr);
        check("latency",   cyc - mon_e.cyc, LAT);
      end
    end
  end

  function automatic int unsigned n_rows(input int m);
    case (m)
      M_PART:   return 10;
      M_BLOCK:  return 160;
      M_SPARSE: return 5;
      M_CORNER: return 480;
      M_EMPTY:  return 4;
      default:  return 300;
    endcase
  endfunction

  function automatic int unsigned width_of(input int m, input int unsigned y);
    case (m)
      M_BLOCK:  return (y >= 50 && y < 150) ? 200 : 1;
      M_CORNER: return (y == 479) ? 640 : 1;
      M_EMPTY:  return 8;
      M_TALL:   return 4;
      default:  return 20;
    endcase
  endfunction

  function automatic logic fg(input int m, input int unsigned x, input int unsigned y);
    case (m)
      M_PART:   return 1'b1;
      M_BLOCK:  return (x >= 100 && x <= 199 && y >= 50 && y <= 149);
      M_SPARSE: return (y == 3 && x >= 5 && x < 15);
      M_CORNER: return ((x == 0 && y == 0) || y == 479);
      M_TALL:   return (x == 1);
      default:  return 1'b0;
    endcase
  endfunction

  task automatic drive_line(input int m, input int unsigned y);
    for (int unsigned x = 0; x < width_of(m, y); x++) begin
      bus.i_de  = 1'b1;
      bus.i_bin = fg(m, x, y);
      @(negedge pixelclk);
    end
    bus.i_de  = 1'b0;
    bus.i_bin = 1'b0;
    @(negedge pixelclk);
    bus.i_hsync = 1'b1;
    @(negedge pixelclk);
    bus.i_hsync = 1'b0;
    @(negedge pixelclk);
  endtask

  task automatic drive_rows(input int m, input int unsigned y0, input int unsigned y1);
    for (int unsigned y = y0; y < y1; y++) drive_line(m, y);
  endtask

  task automatic vsync_edge(input logic pub, input logic ok, input logic [31:0] cnt,
                            input logic [31:0] hl, input logic [31:0] hr,
                            input logic [31:0] vl, input logic [31:0] vr);
    int unsigned p0;
    exp_t e;
    p0 = pulses;
    bus.i_de    = 1'b0;
    bus.i_bin   = 1'b0;
    bus.i_vsync = 1'b1;
    if (pub) begin
      e = '{v: {31'd0, ok}, cnt: cnt, hl: hl, hr: hr, vl: vl, vr: vr, cyc: cyc};
      q.push_back(e);
    end
    repeat (3) @(negedge pixelclk);
    bus.i_vsync = 1'b0;
    repeat (4) @(negedge pixelclk);
    check("pulse_count", pulses - p0, {31'd0, pub});
    check("sb_drain", q.size(), 0);
    q.delete();
  endtask

  // Bounds are held when the frame is below MINP, so the expected box is tracked here.
  task automatic publish(input int unsigned cnt, input int unsigned hl, input int unsigned hr,
                         input int unsigned vl, input int unsigned vr);
    logic ok;
    ok = (cnt >= MINP);
    if (ok) begin
      p_hl = hl;
      p_hr = hr;
      p_vl = vl;
      p_vr = vr;
    end
    vsync_edge(1'b1, ok, cnt, p_hl, p_hr, p_vl, p_vr);
  endtask

  task automatic check_zero(input string phase);
    check({phase, "_hcount_l"}, {20'd0, bus.hcount_l}, 0);
    check({phase, "_hcount_r"}, {20'd0, bus.hcount_r}, 0);
    check({phase, "_vcount_l"}, {20'd0, bus.vcount_l}, 0);
    check({phase, "_vcount_r"}, {20'd0, bus.vcount_r}, 0);
    check({phase, "_valid"}, {31'd0, bus.o_valid}, 0);
    check({phase, "_done"}, {31'd0, bus.o_frame_done}, 0);
    check({phase, "_pix_cnt"}, {12'd0, bus.o_pix_cnt}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    bus.i_bin   = 1'b0;
    bus.i_de    = 1'b0;
    bus.i_hsync = 1'b0;
    bus.i_vsync = 1'b0;
    repeat (3) @(negedge pixelclk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge pixelclk);

    // Partial frame before the first edge: must never be published.
    drive_rows(M_PART, 0, n_rows(M_PART));
    vsync_edge(1'b0, 1'b0, 0, 0, 0, 0, 0);

    drive_rows(M_BLOCK, 0, n_rows(M_BLOCK));
    publish(10000, 99 - MG, 200 + MG, 49 - MG, 150 + MG);
    drive_rows(M_BLOCK, 0, n_rows(M_BLOCK));
    publish(10000, 99 - MG, 200 + MG, 49 - MG, 150 + MG);

    drive_rows(M_EMPTY, 0, n_rows(M_EMPTY));
    publish(0, 0, 0, 0, 0);
    drive_rows(M_SPARSE, 0, n_rows(M_SPARSE));
    publish(10, 0, 0, 0, 0);

    drive_rows(M_CORNER, 0, n_rows(M_CORNER));
    publish(641, 0, 640, 0, 480);

    // Reset mid-frame at line 200: outputs clear without a clock edge.
    drive_rows(M_TALL, 0, 200);
    reset_n = 1'b0;
    #1;
    check_zero("midreset");
    p_hl = 0;
    p_hr = 0;
    p_vl = 0;
    p_vr = 0;
    @(negedge pixelclk);
    @(negedge pixelclk);
    reset_n = 1'b1;
    drive_rows(M_TALL, 200, n_rows(M_TALL));
    vsync_edge(1'b0, 1'b0, 0, 0, 0, 0, 0);
    drive_rows(M_CORNER, 0, n_rows(M_CORNER));
    publish(641, 0, 640, 0, 480);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
